conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_window_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: streams a raster frame through F-1 line buffers and an FxFxCIN window into a fixed-weight conv+ReLU layer.
// Defining CONV_WINDOW_CTRL_PERF_EN adds a saturating input-stall counter output (stall_cnt).

module conv_layer #(
    parameter int WIDTH = 8,
    parameter int N     = 75,
    parameter int ZW    = 23
) (
    input  logic [WIDTH-1:0] x [0:N-1],
    output logic [ZW-1:0]    z
);
    localparam int AW = ZW + 1;

    logic signed [AW-1:0] acc_s;

    // Fixed kernel: weight i is the low WIDTH bits of 37*i+11, read as two's complement.
    function automatic logic signed [AW-1:0] weight(input int i);
        logic [31:0] v;
        v = 32'(i) * 32'd37 + 32'd11;
        return AW'($signed(v[WIDTH-1:0]));
    endfunction

    // Weighted sum over the whole window, then ReLU.
    always_comb begin
        acc_s = {AW{1'b0}};
        for (int i = 0; i < N; i++) begin
            acc_s = acc_s + $signed({{(AW-WIDTH){1'b0}}, x[i]}) * weight(i);
        end
        if (acc_s[AW-1]) begin
            z = {ZW{1'b0}};
        end else begin
            z = acc_s[ZW-1:0];
        end
    end
endmodule

module conv_window_ctrl #(
    parameter int  WIDTH = 8,
    parameter int  IMG_W = 32,
    parameter int  IMG_H = 32,
    localparam int F     = 5,
    localparam int CIN   = 3,
    localparam int ZW    = WIDTH * 2 + $clog2(CIN * F * F)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pix_valid,
    input  logic [CIN*WIDTH-1:0] pix_data,
    output logic                 pix_ready,
    output logic                 res_valid,
    output logic [ZW-1:0]        res_data,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 done
`ifdef CONV_WINDOW_CTRL_PERF_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int N  = CIN * F * F;
    localparam int PW = CIN * WIDTH;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              win_pend_q, win_pend_d;
    logic              res_valid_q, res_valid_d;
    logic [ZW-1:0]     res_data_q, res_data_d;
    logic [WIDTH-1:0]  win_q [0:N-1];
    logic [WIDTH-1:0]  win_d [0:N-1];
    logic [PW-1:0]     lb_q [0:F-2][0:IMG_W-1];
    logic [PW-1:0]     lb_col_d [0:F-2];
    logic [PW-1:0]     new_col_s [0:F-1];
    logic [ZW-1:0]     z_s;
    logic              slot_free_s;
    logic              accept_s;
    logic              last_pix_s;
    logic              win_full_s;
    logic              xfer_s;

    conv_layer #(
        .WIDTH (WIDTH),
        .N     (N),
        .ZW    (ZW)
    ) u_layer (
        .x (win_q),
        .z (z_s)
    );

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        slot_free_s = !res_valid_q || res_ready;
        accept_s    = (state_q == ST_RUN) && slot_free_s && pix_valid;
        last_pix_s  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
        win_full_s  = (row_q >= RW'(F - 1)) && (col_q >= CW'(F - 1));
        xfer_s      = win_pend_q && slot_free_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && last_pix_s) state_d = ST_FLUSH;
                else                        state_d = ST_RUN;
            end
            ST_FLUSH: begin
                if (!win_pend_q && !res_valid_q) state_d = ST_DONE;
                else                             state_d = ST_FLUSH;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        pix_ready = (state_q == ST_RUN) && slot_free_s;
        busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        done      = (state_q == ST_DONE);
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Raster counters, pending-window flag and the output holding register.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        if ((state_q == ST_IDLE) && start) begin
            col_d = {CW{1'b0}};
            row_d = {RW{1'b0}};
        end else if (accept_s) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = {CW{1'b0}};
                if (last_pix_s) row_d = {RW{1'b0}};
                else            row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
        end

        // A new window may arrive on the same edge the previous one moves out.
        if (accept_s && win_full_s) win_pend_d = 1'b1;
        else if (xfer_s)            win_pend_d = 1'b0;
        else                        win_pend_d = win_pend_q;

        if (xfer_s) begin
            res_valid_d = 1'b1;
            res_data_d  = z_s;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            res_data_d  = res_data_q;
        end else begin
            res_valid_d = res_valid_q;
            res_data_d  = res_data_q;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            win_pend_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {ZW{1'b0}};
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_pend_q  <= win_pend_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // New right column = the F-1 buffered rows (oldest first) plus the incoming pixel.
    always_comb begin
        for (int r = 0; r < F - 1; r++) begin
            new_col_s[r] = lb_q[r][col_q];
        end
        new_col_s[F-1] = pix_data;
        for (int j = 0; j < F - 2; j++) begin
            lb_col_d[j] = lb_q[j+1][col_q];
        end
        lb_col_d[F-2] = pix_data;
        for (int c = 0; c < CIN; c++) begin
            for (int r = 0; r < F; r++) begin
                for (int k = 0; k < F; k++) begin
                    if (k < F - 1) begin
                        win_d[c*F*F + r*F + k] = win_q[c*F*F + r*F + k + 1];
                    end else begin
                        win_d[c*F*F + r*F + k] = new_col_s[r][c*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Pixel storage is left unreset; only complete current-frame windows are ever emitted.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int j = 0; j < F - 1; j++) begin
                lb_q[j][col_q] <= lb_col_d[j];
            end
            for (int i = 0; i < N; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

`ifdef CONV_WINDOW_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts RUN cycles where a pixel is offered but refused, saturating.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            stall_cnt_d = 16'h0000;
        end else if ((state_q == ST_RUN) && pix_valid && !slot_free_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl on an 8x6 frame: scenario table plus scoreboard of golden results.
module tb_conv_window_ctrl;
    localparam int WIDTH = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int F     = 5;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int ZW    = 2 * WIDTH + $clog2(75);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            pix_valid = 1'b0;
    logic [23:0]     pix_data = 24'h0;
    logic            pix_ready;
    logic            res_valid;
    logic [ZW-1:0]   res_data;
    logic            res_ready = 1'b1;
    logic            busy;
    logic            done;
`ifdef CONV_WINDOW_CTRL_PERF_EN
    logic [15:0]     stall_cnt;
`endif

    conv_window_ctrl #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
`ifdef CONV_WINDOW_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    pattern;      // 0 zeros, 1 random, 2 all 0xFF
        int    stall_len;    // res_ready low cycles once results flow
        int    start_at;     // pulse start when this pixel index is next, -1 none
        int    abort_at;     // assert rst when this pixel index is next, -1 none
        int    exp_results;
        int    exp_done;
    } scen_t;

    scen_t         tbl [$];
    logic [23:0]   fr [0:NPIX-1];
    logic [ZW-1:0] exp_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [ZW-1:0] golden(input int row, input int col);
        longint acc;
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < F; r++) begin
                for (int k = 0; k < F; k++) begin
                    int v;
                    logic [23:0] px;
                    v = ((c * 25 + r * 5 + k) * 37 + 11) % 256;
                    if (v >= 128) v = v - 256;
                    px = fr[(row - F + 1 + r) * IMG_W + (col - F + 1 + k)];
                    acc = acc + longint'(v) * longint'(px[c*8 +: 8]);
                end
            end
        end
        if (acc < 0) return '0;
        return acc[ZW-1:0];
    endfunction

    task automatic run_frame(input scen_t s);
        int p, nres, ndone, acc36, first_res, last_res, done_cyc, stall_left, n_busy;
        bit stall_done, snap_taken, finished, start_pulsed, aborted, cnt_pending;
        logic [ZW-1:0] snap, ev;
        p = 0; nres = 0; ndone = 0; acc36 = -1; first_res = -1; last_res = -1; done_cyc = -1;
        stall_left = 0; stall_done = 0; snap_taken = 0; finished = 0; start_pulsed = 0;
        aborted = 0; cnt_pending = 0; snap = '0; n_busy = 0;
        for (int i = 0; i < NPIX; i++) begin
            case (s.pattern)
                0:       fr[i] = 24'h000000;
                2:       fr[i] = 24'hFFFFFF;
                default: fr[i] = 24'($urandom);
            endcase
        end
        exp_q.delete();
        @(posedge clk); #1;
        start = 1'b1; pix_valid = 1'b1; pix_data = fr[0]; res_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                nres++;
                if (first_res < 0) first_res = cyc;
                last_res = cyc;
                if (exp_q.size() == 0) begin
                    check({s.name, "_extra_result"}, 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check($sformatf("%s_res%0d", s.name, nres), res_data, ev);
                    if (s.pattern == 0) check($sformatf("%s_zero%0d", s.name, nres), res_data, 0);
                end
            end
            if (!res_ready) begin
                check({s.name, "_bp_valid"}, res_valid, 1);
                check({s.name, "_bp_pix_ready"}, pix_ready, 0);
                if (!snap_taken) begin
                    snap = res_data;
                    snap_taken = 1;
                end else begin
                    check({s.name, "_bp_stable"}, res_data, snap);
                end
            end else if (cnt_pending) begin
                cnt_pending = 0;
`ifdef CONV_WINDOW_CTRL_PERF_EN
                check({s.name, "_stall_cnt"}, stall_cnt, s.stall_len);
`endif
            end
            if (pix_valid && pix_ready) begin
                if (p == 36) acc36 = cyc;
                if ((p / IMG_W) >= F - 1 && (p % IMG_W) >= F - 1)
                    exp_q.push_back(golden(p / IMG_W, p % IMG_W));
                p++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                finished = 1;
            end
            if (s.stall_len > 0 && !stall_done && res_valid && res_ready) begin
                stall_left = s.stall_len;
                stall_done = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (s.start_at >= 0 && p == s.start_at && !start_pulsed) begin
                start = 1'b1;
                start_pulsed = 1;
            end
            if (s.abort_at >= 0 && p == s.abort_at) begin
                rst = 1'b1; pix_valid = 1'b0; start = 1'b0; res_ready = 1'b1;
                aborted = 1;
                break;
            end
            pix_valid = (p < NPIX);
            pix_data  = (p < NPIX) ? fr[p] : 24'h0;
            if (stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) cnt_pending = 1;
            end else begin
                res_ready = 1'b1;
            end
        end
        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done) ndone++;
                if (res_valid) nres++;
                if (busy) n_busy++;
            end
            check({s.name, "_no_done"}, ndone, s.exp_done);
            check({s.name, "_no_results"}, nres, s.exp_results);
            check({s.name, "_idle_busy"}, n_busy, 0);
            exp_q.delete();
            return;
        end
        if (!finished) check({s.name, "_timeout"}, 0, 1);
        pix_valid = 1'b0;
        check({s.name, "_result_count"}, nres, s.exp_results);
        check({s.name, "_done_count"}, ndone, s.exp_done);
        check({s.name, "_queue_empty"}, exp_q.size(), 0);
        check({s.name, "_latency"}, first_res - acc36, 2);
        check({s.name, "_done_after_last"}, (done_cyc > last_res) ? 1 : 0, 1);
        @(negedge clk);
        check({s.name, "_done_one_cycle"}, done, 0);
        check({s.name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{"zero",        0, 0, -1, -1, 8, 1});
        tbl.push_back('{"rand",        1, 0, -1, -1, 8, 1});
        tbl.push_back('{"max",         2, 0, -1, -1, 8, 1});
        tbl.push_back('{"bp5",         1, 5, -1, -1, 8, 1});
        tbl.push_back('{"abort20",     1, 0, -1, 20, 0, 0});
        tbl.push_back('{"after_abort", 1, 0, -1, -1, 8, 1});
        tbl.push_back('{"start_in_run",1, 0, 10, -1, 8, 1});
        tbl.push_back('{"bp7",         1, 7, -1, -1, 8, 1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data",  res_data, 0);
        check("rst_busy",      busy, 0);
        check("rst_done",      done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_pix_ready", pix_ready, 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i]);
            repeat (2) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
